uart_rx_fifo_ctrl: RTL

//  Receive-side controller between uart_rx and the APB register file.
//  - Captures each received character (rx_done pulse) into an RX FIFO.
//  - Drives rts_n flow control from the FIFO fill level.
//  - Keeps sticky overrun and parity-error status.
//  - Raises level, timeout and error interrupts for the APB/IRQ logic.

---
 rtl/uart_rx_fifo_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo_ctrl.sv
// Receive-side FIFO controller: buffers received characters, drives rts_n flow control,
// keeps sticky overrun/parity status and raises level, timeout and error interrupts.
module uart_rx_fifo_ctrl #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned TIMEOUT_TICKS = 640,
    localparam int unsigned AW           = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_tick_i,
    input  logic              rx_done_i,
    input  logic              parity_error_i,
    input  logic [31:0]       rx_data_i,
    input  logic              rx_en_i,
    input  logic              flush_i,
    input  logic              clr_status_i,
    input  logic [AW:0]       irq_thresh_i,
    input  logic [AW:0]       rts_thresh_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_perr_o,
    output logic [AW:0]       level_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              overrun_o,
    output logic              perr_o,
    output logic              rts_n_o,
    output logic              irq_level_o,
    output logic              irq_timeout_o,
    output logic              irq_err_o,
    output logic              irq_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_TICKS - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COUNT   = 2'd1;
    localparam logic [1:0] ST_EXPIRED = 2'd2;

    logic [DATA_W:0]   r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_level;
    logic              r_empty;
    logic              r_full;
    logic              r_overrun;
    logic              r_perr;
    logic              r_rts_n;
    logic              r_irq_level;
    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;

    logic              w_push;
    logic              w_pop;
    logic              w_overrun_set;
    logic [AW:0]       w_level_next;
    logic [1:0]        w_state_next;
    logic [CW-1:0]     w_cnt_next;
    logic [DATA_W:0]   w_head;
    logic              w_unused_data;

    assign w_unused_data = ^rx_data_i;

    // A push into a full FIFO is legal when a pop frees the head slot in the same cycle.
    assign w_push        = rx_done_i & rx_en_i & (~r_full | rd_en_i);
    assign w_pop         = rd_en_i & ~r_empty;
    assign w_overrun_set = rx_done_i & rx_en_i & r_full & ~rd_en_i;

    always_comb begin
        w_level_next = r_level;
        if (flush_i) begin
            w_level_next = '0;
        end else if (w_push && !w_pop) begin
            w_level_next = r_level + (AW+1)'(1);
        end else if (w_pop && !w_push) begin
            w_level_next = r_level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush_i) begin
            r_mem[r_wptr] <= {parity_error_i, rx_data_i[DATA_W-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_rts_n     <= 1'b1;
            r_irq_level <= 1'b0;
        end else begin
            if (flush_i) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + AW'(1);
                if (w_pop)  r_rptr <= r_rptr + AW'(1);
            end
            r_level     <= w_level_next;
            r_empty     <= (w_level_next == '0);
            r_full      <= (w_level_next == (AW+1)'(DEPTH));
            r_rts_n     <= (w_level_next >= rts_thresh_i);
            r_irq_level <= (irq_thresh_i != '0) && (w_level_next >= irq_thresh_i);
        end
    end

    // A set in the same cycle as a clear wins, so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_overrun <= w_overrun_set | (r_overrun & ~clr_status_i);
            r_perr    <= (w_push & parity_error_i) | (r_perr & ~clr_status_i);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (flush_i) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_next = '0;
                    if (w_level_next != '0) w_state_next = ST_COUNT;
                end
                ST_COUNT: begin
                    if (w_level_next == '0) begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                    end else if (w_push || w_pop) begin
                        w_cnt_next = '0;
                    end else if (rx_tick_i) begin
                        if (r_cnt == CNT_MAX) begin
                            w_state_next = ST_EXPIRED;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + CW'(1);
                        end
                    end
                end
                ST_EXPIRED: begin
                    if (w_pop) begin
                        w_cnt_next   = '0;
                        w_state_next = (w_level_next == '0) ? ST_IDLE : ST_COUNT;
                    end else if (w_push) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_COUNT;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign w_head        = r_mem[r_rptr];
    assign rd_data_o     = r_empty ? '0 : w_head[DATA_W-1:0];
    assign rd_perr_o     = r_empty ? 1'b0 : w_head[DATA_W];
    assign level_o       = r_level;
    assign empty_o       = r_empty;
    assign full_o        = r_full;
    assign overrun_o     = r_overrun;
    assign perr_o        = r_perr;
    assign rts_n_o       = r_rts_n;
    assign irq_level_o   = r_irq_level;
    assign irq_timeout_o = (r_state == ST_EXPIRED);
    assign irq_err_o     = r_overrun | r_perr;
    assign irq_o         = r_irq_level | irq_timeout_o | irq_err_o;

endmodule
